// File: rtl/aclint_mtimer_if.sv
// 32-bit AXI4-Lite bus bundle shared by the peripheral crossbar and its slaves.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/aclint_mtimer.sv
// Machine timer / software interrupt block: writable prescaled mtime, per-hart
// mtimecmp and msip, exposed as an AXI4-Lite slave.
module aclint_mtimer #(
    parameter logic [31:0] BASE_ADDR = 32'h0a00_0000,
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    axi_lite_if.slave            s,
    output logic [NUM_HARTS-1:0] msip,
    output logic [NUM_HARTS-1:0] mtip
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {SEL_MSIP, SEL_CMP, SEL_MTIME, SEL_NONE} sel_e;
    typedef struct packed {
        sel_e       sel;
        logic [2:0] hart;
        logic       hi;
    } dec_t;

    typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    logic [63:0]      mtime;
    logic [CNT_W-1:0] tick_cnt;
    logic [63:0]      mtimecmp [NUM_HARTS];

    wr_state_e   wr_state;
    rd_state_e   rd_state;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;

    // Address map decode; anything outside the window, misaligned, or past NUM_HARTS is unmapped.
    function automatic dec_t decode(input logic [31:0] addr);
        dec_t d;
        d.sel  = SEL_NONE;
        d.hart = 3'd0;
        d.hi   = 1'b0;
        if (addr[31:16] == BASE_ADDR[31:16] && addr[1:0] == 2'b00) begin
            if (addr[15:5] == 11'h0 && 32'(addr[4:2]) < NUM_HARTS) begin
                d.sel  = SEL_MSIP;
                d.hart = addr[4:2];
            end else if (addr[15:6] == 10'h100 && 32'(addr[5:3]) < NUM_HARTS) begin
                d.sel  = SEL_CMP;
                d.hart = addr[5:3];
                d.hi   = addr[2];
            end else if (addr[15:3] == 13'h17FF) begin
                d.sel  = SEL_MTIME;
                d.hi   = addr[2];
            end
        end
        return d;
    endfunction

    logic        aw_hs, w_hs, ar_hs;
    logic        wr_fire;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    dec_t        wr_dec;
    dec_t        rd_dec;
    logic [31:0] rd_val;

    assign aw_hs  = s.awvalid && s.awready;
    assign w_hs   = s.wvalid && s.wready;
    assign ar_hs  = s.arvalid && s.arready;
    assign wr_dec = decode(wr_addr);
    assign rd_dec = decode(s.araddr);

    // Register write strobe fires on the edge completing the later of AW and W.
    always_comb begin
        wr_fire = 1'b0;
        wr_addr = aw_addr_q;
        wr_data = w_data_q;
        case (wr_state)
            WR_IDLE: begin
                wr_fire = aw_hs && w_hs;
                wr_addr = s.awaddr;
                wr_data = s.wdata;
            end
            WR_WAIT_W: begin
                wr_fire = w_hs;
                wr_data = s.wdata;
            end
            WR_WAIT_AW: begin
                wr_fire = aw_hs;
                wr_addr = s.awaddr;
            end
            default: wr_fire = 1'b0;
        endcase
    end

    always_comb begin
        rd_val = 32'd0;
        case (rd_dec.sel)
            SEL_MSIP: begin
                for (int h = 0; h < NUM_HARTS; h++)
                    if (rd_dec.hart == 3'(h)) rd_val = {31'd0, msip[h]};
            end
            SEL_CMP: begin
                for (int h = 0; h < NUM_HARTS; h++)
                    if (rd_dec.hart == 3'(h))
                        rd_val = rd_dec.hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
            end
            SEL_MTIME: rd_val = rd_dec.hi ? mtime[63:32] : mtime[31:0];
            default:   rd_val = 32'd0;
        endcase
    end

    // A software write to mtime wins over the tick and restarts the prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime    <= 64'd0;
            tick_cnt <= '0;
        end else if (wr_fire && wr_dec.sel == SEL_MTIME) begin
            if (wr_dec.hi) mtime[63:32] <= wr_data;
            else           mtime[31:0]  <= wr_data;
            tick_cnt <= '0;
        end else if (tick_cnt == CNT_MAX) begin
            mtime    <= mtime + 64'd1;
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtimecmp[h] <= '1;
                msip[h]     <= 1'b0;
                mtip[h]     <= 1'b0;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtip[h] <= (mtime >= mtimecmp[h]);
                if (wr_fire && wr_dec.hart == 3'(h)) begin
                    if (wr_dec.sel == SEL_MSIP) msip[h] <= wr_data[0];
                    if (wr_dec.sel == SEL_CMP) begin
                        if (wr_dec.hi) mtimecmp[h][63:32] <= wr_data;
                        else           mtimecmp[h][31:0]  <= wr_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state  <= WR_IDLE;
            s.awready <= 1'b1;
            s.wready  <= 1'b1;
            s.bvalid  <= 1'b0;
            s.bresp   <= RESP_OKAY;
            aw_addr_q <= 32'd0;
            w_data_q  <= 32'd0;
        end else if (wr_fire) begin
            wr_state  <= WR_RESP;
            s.awready <= 1'b0;
            s.wready  <= 1'b0;
            s.bvalid  <= 1'b1;
            s.bresp   <= (wr_dec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= s.awaddr;
                        s.awready <= 1'b0;
                        wr_state  <= WR_WAIT_W;
                    end else if (w_hs) begin
                        w_data_q  <= s.wdata;
                        s.wready  <= 1'b0;
                        wr_state  <= WR_WAIT_AW;
                    end
                end
                WR_RESP: begin
                    if (s.bready) begin
                        s.bvalid  <= 1'b0;
                        s.awready <= 1'b1;
                        s.wready  <= 1'b1;
                        wr_state  <= WR_IDLE;
                    end
                end
                default: wr_state <= wr_state;
            endcase
        end
    end

    // Read data is snapshotted at the AR handshake and held until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state  <= RD_IDLE;
            s.arready <= 1'b1;
            s.rvalid  <= 1'b0;
            s.rdata   <= 32'd0;
            s.rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        s.rdata   <= rd_val;
                        s.rresp   <= (rd_dec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                        s.rvalid  <= 1'b1;
                        s.arready <= 1'b0;
                        rd_state  <= RD_RESP;
                    end
                end
                default: begin
                    if (s.rready) begin
                        s.rvalid  <= 1'b0;
                        s.arready <= 1'b1;
                        rd_state  <= RD_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aclint_mtimer.sv
// Drives two timer instances (2 harts / TICK_DIV 1 and 1 hart / TICK_DIV 4) from one
// AXI master and compares every response and interrupt line against an edge-indexed model.
module tb_aclint_mtimer;
    localparam logic [31:0] BASE = 32'h0a00_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [1:0] msip_a, mtip_a;
    logic [0:0] msip_b, mtip_b;

    axi_lite_if bus_a ();
    axi_lite_if bus_b ();
    assign bus_a.awaddr = awaddr;  assign bus_b.awaddr = awaddr;
    assign bus_a.awvalid = awvalid; assign bus_b.awvalid = awvalid;
    assign bus_a.wdata = wdata;    assign bus_b.wdata = wdata;
    assign bus_a.wstrb = 4'hF;     assign bus_b.wstrb = 4'hF;
    assign bus_a.wvalid = wvalid;  assign bus_b.wvalid = wvalid;
    assign bus_a.bready = bready;  assign bus_b.bready = bready;
    assign bus_a.araddr = araddr;  assign bus_b.araddr = araddr;
    assign bus_a.arvalid = arvalid; assign bus_b.arvalid = arvalid;
    assign bus_a.rready = rready;  assign bus_b.rready = rready;

    aclint_mtimer #(.BASE_ADDR(BASE), .NUM_HARTS(2), .TICK_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .s(bus_a), .msip(msip_a), .mtip(mtip_a));
    aclint_mtimer #(.BASE_ADDR(BASE), .NUM_HARTS(1), .TICK_DIV(4)) dut_b (
        .clk(clk), .reset(reset), .s(bus_b), .msip(msip_b), .mtip(mtip_b));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: each register's value after edge e, from its last write edge.
    int          td [2] = '{1, 4};
    int          nh [2] = '{2, 1};
    logic [63:0] base [2], pbase [2];
    int          anch [2], panch [2];
    logic [63:0] cmp_new [2][2], cmp_old [2][2];
    int          cmp_edge [2][2];
    bit          sw_new [2][2], sw_old [2][2];
    int          sw_edge [2][2];

    function automatic logic [63:0] mt(input int k, input int e);
        if (e >= anch[k])  return base[k] + 64'((e - anch[k]) / td[k]);
        if (e >= panch[k]) return pbase[k] + 64'((e - panch[k]) / td[k]);
        return 64'd0;
    endfunction

    function automatic logic [63:0] cmpv(input int k, input int h, input int e);
        return (e >= cmp_edge[k][h]) ? cmp_new[k][h] : cmp_old[k][h];
    endfunction

    function automatic bit swv(input int k, input int h, input int e);
        return (e >= sw_edge[k][h]) ? sw_new[k][h] : sw_old[k][h];
    endfunction

    function automatic void model_reset(input int e);
        for (int k = 0; k < 2; k++) begin
            base[k] = 64'd0; pbase[k] = 64'd0; anch[k] = e; panch[k] = e;
            for (int h = 0; h < 2; h++) begin
                cmp_new[k][h] = '1; cmp_old[k][h] = '1; cmp_edge[k][h] = e;
                sw_new[k][h] = 1'b0; sw_old[k][h] = 1'b0; sw_edge[k][h] = e;
            end
        end
    endfunction

    // kind: 0 msip, 1 mtimecmp, 2 mtime, 3 unmapped
    function automatic void mdec(input int k, input logic [31:0] a,
                                 output int kind, output int h, output bit hi);
        logic [31:0] off;
        kind = 3; h = 0; hi = 1'b0;
        if (a < BASE || a >= BASE + 32'h1_0000 || a[1:0] != 2'b00) return;
        off = a - BASE;
        if (off < 32'(4 * nh[k])) begin
            kind = 0; h = int'(off / 4);
        end else if (off >= 32'h4000 && off < 32'h4000 + 32'(8 * nh[k])) begin
            kind = 1; h = int'((off - 32'h4000) / 8); hi = (off % 8) == 4;
        end else if (off == 32'hBFF8 || off == 32'hBFFC) begin
            kind = 2; hi = (off == 32'hBFFC);
        end
    endfunction

    function automatic logic [1:0] model_write(input int k, input logic [31:0] a,
                                               input logic [31:0] d, input int w);
        int kind, h; bit hi; logic [63:0] old; bit ob;
        mdec(k, a, kind, h, hi);
        case (kind)
            0: begin ob = swv(k, h, w - 1); sw_old[k][h] = ob; sw_new[k][h] = d[0]; sw_edge[k][h] = w; end
            1: begin
                old = cmpv(k, h, w - 1);
                cmp_old[k][h] = old;
                cmp_new[k][h] = hi ? {d, old[31:0]} : {old[63:32], d};
                cmp_edge[k][h] = w;
            end
            2: begin
                old = mt(k, w - 1);
                pbase[k] = base[k]; panch[k] = anch[k];
                base[k] = hi ? {d, old[31:0]} : {old[63:32], d};
                anch[k] = w;
            end
            default: return 2'b10;
        endcase
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input int k, input logic [31:0] a,
                                               input int n, output logic [1:0] resp);
        int kind, h; bit hi; logic [63:0] v;
        mdec(k, a, kind, h, hi);
        resp = 2'b00;
        case (kind)
            0: return {31'd0, swv(k, h, n - 1)};
            1: begin v = cmpv(k, h, n - 1); return hi ? v[63:32] : v[31:0]; end
            2: begin v = mt(k, n - 1); return hi ? v[63:32] : v[31:0]; end
            default: begin resp = 2'b10; return 32'd0; end
        endcase
    endfunction

    // Interrupt lines are checked every cycle outside reset.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] ea, es;
            for (int h = 0; h < 2; h++) begin
                ea[h] = mt(0, cyc - 1) >= cmpv(0, h, cyc - 1);
                es[h] = swv(0, h, cyc);
            end
            check("mtip_a", 64'(mtip_a), 64'(ea));
            check("msip_a", 64'(msip_a), 64'(es));
            check("mtip_b", 64'(mtip_b), 64'(mt(1, cyc - 1) >= cmpv(1, 0, cyc - 1)));
            check("msip_b", 64'(msip_b), 64'(swv(1, 0, cyc)));
        end
    end

    function automatic bit sig(input int which);
        case (which)
            0: return bus_a.awready & bus_b.awready;
            1: return bus_a.wready & bus_b.wready;
            2: return bus_a.bvalid & bus_b.bvalid;
            3: return bus_a.arready & bus_b.arready;
            4: return bus_a.rvalid & bus_b.rvalid;
            default: return bus_a.awready & bus_a.wready & bus_b.awready & bus_b.wready;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where the selected signal is high.
    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (!sig(which)) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL %s: no handshake within %0d cycles, required one", tag, n);
                return;
            end
        end
    endtask

    // mode 0: AW and W together, 1: W leads AW by lead cycles, 2: AW leads W.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input int mode, input int lead, input int hold);
        int w; logic [1:0] er [2];
        if (mode == 0) begin
            awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
            wait_for(5, "aw_w");
        end else if (mode == 1) begin
            wdata = d; wvalid = 1'b1;
            wait_for(1, "w_first");
            @(negedge clk); wvalid = 1'b0;
            repeat (lead) @(negedge clk);
            awaddr = a; awvalid = 1'b1;
            wait_for(0, "aw_second");
        end else begin
            awaddr = a; awvalid = 1'b1;
            wait_for(0, "aw_first");
            @(negedge clk); awvalid = 1'b0;
            repeat (lead) @(negedge clk);
            wdata = d; wvalid = 1'b1;
            wait_for(1, "w_second");
        end
        w = cyc + 1;
        for (int k = 0; k < 2; k++) er[k] = model_write(k, a, d, w);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_lat", 64'(sig(2)), 64'd1);
        wait_for(2, "bvalid");
        check("bresp_a", 64'(bus_a.bresp), 64'(er[0]));
        check("bresp_b", 64'(bus_b.bresp), 64'(er[1]));
        repeat (hold) begin
            @(negedge clk);
            check("bvalid_hold", 64'(sig(2)), 64'd1);
            check("bresp_hold_a", 64'(bus_a.bresp), 64'(er[0]));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_drop", 64'(bus_a.bvalid | bus_b.bvalid), 64'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold);
        int n; logic [31:0] ed [2]; logic [1:0] er [2];
        araddr = a; arvalid = 1'b1;
        wait_for(3, "arready");
        n = cyc + 1;
        @(negedge clk);
        arvalid = 1'b0;
        for (int k = 0; k < 2; k++) ed[k] = model_read(k, a, n, er[k]);
        check("rvalid_lat", 64'(sig(4)), 64'd1);
        wait_for(4, "rvalid");
        check("rdata_a", 64'(bus_a.rdata), 64'(ed[0]));
        check("rresp_a", 64'(bus_a.rresp), 64'(er[0]));
        check("rdata_b", 64'(bus_b.rdata), 64'(ed[1]));
        check("rresp_b", 64'(bus_b.rresp), 64'(er[1]));
        repeat (hold) begin
            @(negedge clk);
            check("rvalid_hold", 64'(sig(4)), 64'd1);
            check("rdata_hold_a", 64'(bus_a.rdata), 64'(ed[0]));
            check("rdata_hold_b", 64'(bus_b.rdata), 64'(ed[1]));
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_drop", 64'(bus_a.rvalid | bus_b.rvalid), 64'd0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset(cyc);
        mon_en = 1'b1;
    endtask

    logic [31:0] addr_tab [14] = '{32'h0, 32'h4, 32'h8, 32'h4000, 32'h4004, 32'h4008, 32'h400C,
                                   32'h4010, 32'hBFF8, 32'hBFFC, 32'hBFF9, 32'h1000, 32'hFFFC,
                                   32'h1_0000};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();
        check("reset_bvalid", 64'(bus_a.bvalid | bus_b.bvalid), 64'd0);
        check("reset_ready", 64'(sig(5) & sig(3)), 64'd1);

        // mtime advances; mtimecmp resets to all ones
        repeat (10) @(negedge clk);
        axi_read(BASE + 32'hBFF8, 0);
        repeat (8) @(negedge clk);
        axi_read(BASE + 32'hBFF8, 0);
        axi_read(BASE + 32'h4000, 0);
        axi_read(BASE + 32'h4004, 0);

        // mtimecmp[0] = 100, then push it far out
        axi_write(BASE + 32'h4004, 32'd0, 0, 1, 0);
        axi_write(BASE + 32'h4000, 32'd100, 0, 1, 0);
        repeat (120) @(negedge clk);
        axi_write(BASE + 32'h4004, 32'd1, 0, 1, 0);
        repeat (4) @(negedge clk);

        // wrap of mtime with a zero compare on hart 1
        axi_write(BASE + 32'h4008, 32'd0, 0, 1, 0);
        axi_write(BASE + 32'h400C, 32'd0, 0, 1, 0);
        axi_write(BASE + 32'hBFFC, 32'hFFFF_FFFF, 0, 1, 0);
        axi_write(BASE + 32'hBFF8, 32'hFFFF_FFFE, 0, 1, 0);
        axi_read(BASE + 32'hBFF8, 0);
        axi_read(BASE + 32'hBFFC, 0);
        repeat (10) @(negedge clk);
        axi_read(BASE + 32'hBFFC, 0);

        // prescaler restart at varied distances from the write edge
        for (int d = 0; d < 6; d++) begin
            axi_write(BASE + 32'hBFF8, 32'd50, 0, 1, 0);
            repeat (d) @(negedge clk);
            axi_read(BASE + 32'hBFF8, 0);
        end
        repeat (40) @(negedge clk);
        axi_read(BASE + 32'hBFF8, 0);

        // msip and unmapped accesses
        axi_write(BASE + 32'h0004, 32'hFFFF_FFFF, 0, 1, 0);
        axi_read(BASE + 32'h0004, 0);
        axi_read(BASE + 32'h0008, 0);
        axi_read(BASE + 32'h4010, 0);
        axi_read(BASE + 32'hBFF9, 0);
        axi_write(BASE + 32'h0008, 32'h1, 0, 1, 0);
        axi_write(BASE + 32'hBFF9, 32'h1234, 0, 1, 0);

        // channel ordering and back-pressure
        axi_write(BASE + 32'h0000, 32'h1, 1, 3, 5);
        axi_write(BASE + 32'h4000, 32'h55, 2, 3, 0);
        axi_write(BASE + 32'h4004, 32'h0, 0, 1, 5);
        axi_read(BASE + 32'h4000, 5);
        axi_read(BASE + 32'h0000, 0);

        // reset while waiting for W aborts the write
        awaddr = BASE + 32'hBFF8; awvalid = 1'b1;
        wait_for(0, "aw_only");
        @(negedge clk);
        awvalid = 1'b0;
        check("wait_w_awready", 64'(bus_a.awready), 64'd0);
        check("wait_w_wready", 64'(bus_a.wready), 64'd1);
        do_reset();
        repeat (5) begin
            @(negedge clk);
            check("abort_bvalid", 64'(bus_a.bvalid | bus_b.bvalid), 64'd0);
        end
        axi_read(BASE + 32'h4000, 0);
        axi_read(BASE + 32'h0004, 0);
        axi_read(BASE + 32'hBFF8, 0);

        // randomized traffic, sometimes read and write overlapping
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, ra, d;
            int op;
            a  = BASE + addr_tab[$urandom_range(0, 13)];
            ra = BASE + addr_tab[$urandom_range(0, 13)];
            d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 400));
            op = $urandom_range(0, 2);
            if (op == 0) axi_read(ra, $urandom_range(0, 2));
            else if (op == 1) axi_write(a, d, $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2));
            else fork
                axi_write(a, d, 0, 1, $urandom_range(0, 2));
                axi_read(a, $urandom_range(0, 2));
            join
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
